// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with registered difference/borrow outputs and a one-cycle done pulse.
module serial_full_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Data_in_Start,
  input  logic [WIDTH-1:0] Data_in_A,
  input  logic [WIDTH-1:0] Data_in_B,
  input  logic             Data_in_Borrow,
  output logic [WIDTH-1:0] Data_out_Diff,
  output logic             Data_out_Borrow,
  output logic             Data_out_Busy,
  output logic             Data_out_Done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               bw_q, bw_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cell_diff;
  logic               cell_borrow;
  logic [WIDTH-1:0]   res_shift;
  logic [WIDTH-1:0]   a_shift;
  logic [WIDTH-1:0]   b_shift;

  // Full-subtractor cell on the current LSBs and the running borrow.
  always_comb begin
    cell_diff   = a_q[0] ^ b_q[0] ^ bw_q;
    cell_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
    res_shift   = {cell_diff, res_q[WIDTH-1:1]};
    a_shift     = {1'b0, a_q[WIDTH-1:1]};
    b_shift     = {1'b0, b_q[WIDTH-1:1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      IDLE: begin
        if (Data_in_Start) begin
          state_d = RUN;
          a_d     = Data_in_A;
          b_d     = Data_in_B;
          bw_d    = Data_in_Borrow;
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_shift;
        b_d   = b_shift;
        bw_d  = cell_borrow;
        res_d = res_shift;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          diff_d   = res_shift;
          borrow_d = cell_borrow;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bw_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bw_q     <= bw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Data_out_Diff   = diff_q;
  assign Data_out_Borrow = borrow_q;
  assign Data_out_Busy   = busy_q;
  assign Data_out_Done   = done_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Self-checking bench for serial_full_subtractor: directed vectors, start/reset
// corner cases, random operands at WIDTH=8 and an exhaustive sweep at WIDTH=4.
module tb_serial_full_subtractor;

  localparam int unsigned W8 = 8;
  localparam int unsigned W4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          s8, bin8, bo8, busy8, done8;
  logic [W8-1:0] a8, b8, diff8;
  logic          s4, bin4, bo4, busy4, done4;
  logic [W4-1:0] a4, b4, diff4;

  int checks;
  int passes;

  logic [W8-1:0] prev_diff;
  logic          prev_bw;

  serial_full_subtractor #(.WIDTH(W8)) dut8 (
    .clk(clk), .reset(reset), .Data_in_Start(s8),
    .Data_in_A(a8), .Data_in_B(b8), .Data_in_Borrow(bin8),
    .Data_out_Diff(diff8), .Data_out_Borrow(bo8),
    .Data_out_Busy(busy8), .Data_out_Done(done8)
  );

  serial_full_subtractor #(.WIDTH(W4)) dut4 (
    .clk(clk), .reset(reset), .Data_in_Start(s4),
    .Data_in_A(a4), .Data_in_B(b4), .Data_in_Borrow(bin4),
    .Data_out_Diff(diff4), .Data_out_Borrow(bo4),
    .Data_out_Busy(busy4), .Data_out_Done(done4)
  );

  // Reference: unsigned (a - b - bin) mod 2^w, borrow when a < b + bin.
  function automatic void model(input int unsigned w, input int unsigned a,
                                input int unsigned b, input int unsigned bin,
                                output int unsigned diff, output logic bw);
    int unsigned m;
    m    = 32'd1 << w;
    diff = (a + m - b - bin) % m;
    bw   = (a < b + bin);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=8 operation and record what the DUT shows over 12 cycles.
  task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic bin,
                      input int restart_j, output int done_cnt, output int done_j,
                      output int busy_cnt, output int hold_bad,
                      output logic [W8-1:0] d_at, output logic bw_at);
    done_cnt = 0; done_j = -1; busy_cnt = 0; hold_bad = 0;
    d_at = 'x; bw_at = 1'bx;
    a8 = a; b8 = b; bin8 = bin; s8 = 1'b1;
    for (int j = 0; j <= int'(W8) + 3; j++) begin
      tick();
      if (done8 === 1'b1) begin
        done_cnt++;
        if (done_j < 0) begin
          done_j = j; d_at = diff8; bw_at = bo8;
        end
      end
      if (busy8 === 1'b1) busy_cnt++;
      if (done_j < 0 && (diff8 !== prev_diff || bo8 !== prev_bw)) hold_bad++;
      s8 = (j + 1 == restart_j);
      if (j + 1 == restart_j) begin
        a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
    end
    s8 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({diff8, bo8, busy8, done8} !== 11'b0)
      $display("FAIL reset8 got diff=%h bw=%b busy=%b done=%b required all 0", diff8, bo8, busy8, done8);
    else passes++;
    checks++;
    if ({diff4, bo4, busy4, done4} !== 7'b0)
      $display("FAIL reset4 got diff=%h bw=%b busy=%b done=%b required all 0", diff4, bo4, busy4, done4);
    else passes++;
    reset = 1'b0;
    prev_diff = '0;
    prev_bw = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [W8-1:0] ta [4];
    logic [W8-1:0] tb [4];
    logic          tbin [4];
    int dc, dj, bc, hb;
    logic [W8-1:0] d;
    logic bw, ebw;
    int unsigned ed;
    ta = '{8'h5A, 8'h00, 8'hFF, 8'h80};
    tb = '{8'h23, 8'h01, 8'hFF, 8'h00};
    tbin = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      model(W8, int'(ta[i]), int'(tb[i]), int'(tbin[i]), ed, ebw);
      run8(ta[i], tb[i], tbin[i], -1, dc, dj, bc, hb, d, bw);
      checks++;
      if (dc != 1 || dj != int'(W8))
        $display("FAIL dir%0d_done got count=%0d at=%0d required count=1 at=%0d", i, dc, dj, W8);
      else passes++;
      checks++;
      if (bc != int'(W8) + 1)
        $display("FAIL dir%0d_busy got %0d cycles required %0d", i, bc, W8 + 1);
      else passes++;
      checks++;
      if (hb != 0)
        $display("FAIL dir%0d_hold got %0d changed cycles required 0", i, hb);
      else passes++;
      checks++;
      if (d !== 8'(ed) || bw !== ebw)
        $display("FAIL dir%0d_result got diff=%h bw=%b required diff=%h bw=%b", i, d, bw, 8'(ed), ebw);
      else passes++;
      prev_diff = 8'(ed);
      prev_bw = ebw;
    end
  endtask

  task automatic test_start_ignored();
    int dc, dj, bc, hb;
    logic [W8-1:0] d;
    logic bw;
    run8(8'h10, 8'h01, 1'b0, 3, dc, dj, bc, hb, d, bw);
    checks++;
    if (dc != 1 || dj != int'(W8))
      $display("FAIL ignore_done got count=%0d at=%0d required count=1 at=%0d", dc, dj, W8);
    else passes++;
    checks++;
    if (bc != int'(W8) + 1)
      $display("FAIL ignore_busy got %0d cycles required %0d", bc, W8 + 1);
    else passes++;
    checks++;
    if (hb != 0)
      $display("FAIL ignore_hold got %0d changed cycles required 0", hb);
    else passes++;
    checks++;
    if (d !== 8'h0F || bw !== 1'b0)
      $display("FAIL ignore_result got diff=%h bw=%b required diff=0f bw=0", d, bw);
    else passes++;
    prev_diff = 8'h0F;
    prev_bw = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dc, dj, bc, hb, early_done;
    logic [W8-1:0] d;
    logic bw;
    early_done = 0;
    a8 = 8'h77; b8 = 8'h12; bin8 = 1'b1; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      if (done8 === 1'b1) early_done++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({diff8, bo8, busy8, done8} !== 11'b0)
      $display("FAIL midreset_clear got diff=%h bw=%b busy=%b done=%b required all 0", diff8, bo8, busy8, done8);
    else passes++;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (done8 === 1'b1 || busy8 === 1'b1) early_done++;
    end
    checks++;
    if (early_done != 0)
      $display("FAIL midreset_nodone got %0d done/busy cycles required 0", early_done);
    else passes++;
    prev_diff = '0;
    prev_bw = 1'b0;
    run8(8'h03, 8'h05, 1'b0, -1, dc, dj, bc, hb, d, bw);
    checks++;
    if (dc != 1 || dj != int'(W8) || hb != 0)
      $display("FAIL midreset_next got count=%0d at=%0d hold=%0d required 1/%0d/0", dc, dj, hb, W8);
    else passes++;
    checks++;
    if (d !== 8'hFE || bw !== 1'b1)
      $display("FAIL midreset_result got diff=%h bw=%b required diff=fe bw=1", d, bw);
    else passes++;
    prev_diff = 8'hFE;
    prev_bw = 1'b1;
  endtask

  task automatic test_random();
    int dc, dj, bc, hb;
    logic [W8-1:0] d, ra, rb;
    logic bw, rbin, ebw;
    int unsigned ed;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      model(W8, int'(ra), int'(rb), int'(rbin), ed, ebw);
      run8(ra, rb, rbin, -1, dc, dj, bc, hb, d, bw);
      checks++;
      if (dc != 1 || dj != int'(W8) || bc != int'(W8) + 1 || hb != 0)
        $display("FAIL rand%0d_timing got count=%0d at=%0d busy=%0d hold=%0d", i, dc, dj, bc, hb);
      else passes++;
      checks++;
      if (d !== 8'(ed) || bw !== ebw)
        $display("FAIL rand%0d_result a=%h b=%h bin=%b got diff=%h bw=%b required diff=%h bw=%b",
                 i, ra, rb, rbin, d, bw, 8'(ed), ebw);
      else passes++;
      prev_diff = 8'(ed);
      prev_bw = ebw;
    end
  endtask

  // Start held high: each new operand set is accepted every WIDTH+2 cycles.
  task automatic test_exhaustive();
    int unsigned ed;
    logic ebw;
    int bad_pulse;
    a4 = 4'(0); b4 = 4'(0); bin4 = 1'b0; s4 = 1'b1;
    for (int n = 0; n < 512; n++) begin
      model(W4, int'(a4), int'(b4), int'(bin4), ed, ebw);
      bad_pulse = 0;
      tick();
      if (busy4 !== 1'b1 || done4 !== 1'b0) bad_pulse++;
      for (int j = 1; j <= int'(W4) + 1; j++) begin
        tick();
        if (j == int'(W4)) begin
          if (done4 !== 1'b1 || busy4 !== 1'b1) bad_pulse++;
          checks++;
          if (diff4 !== 4'(ed))
            $display("FAIL exh_diff a=%h b=%h bin=%b got %h required %h", a4, b4, bin4, diff4, 4'(ed));
          else passes++;
          checks++;
          if (bo4 !== ebw)
            $display("FAIL exh_borrow a=%h b=%h bin=%b got %b required %b", a4, b4, bin4, bo4, ebw);
          else passes++;
        end else if (j < int'(W4)) begin
          if (done4 !== 1'b0 || busy4 !== 1'b1) bad_pulse++;
        end else begin
          if (done4 !== 1'b0 || busy4 !== 1'b0) bad_pulse++;
        end
      end
      checks++;
      if (bad_pulse != 0)
        $display("FAIL exh_timing a=%h b=%h bin=%b got %0d bad cycles required 0", a4, b4, bin4, bad_pulse);
      else passes++;
      if (n == 511) begin
        s4 = 1'b0;
      end else begin
        a4 = 4'(n + 1); b4 = 4'((n + 1) >> 4); bin4 = 1'((n + 1) >> 8);
      end
    end
  endtask

  initial begin
    checks = 0; passes = 0;
    reset = 1'b1;
    s8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    s4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    prev_diff = '0; prev_bw = 1'b0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_exhaustive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
